button_event_gen: RTL and testbench

- Consumes the debounced, synchronized button levels and converts them into discrete, timestamp-free input events for the game logic: PRESS, RELEASE, LONG (long press) and REPEAT (auto-repeat while held).
- Per-button state machines feed a fixed-priority arbiter into a small event FIFO.
- The game logic pops events with a valid/ready handshake.

---
 rtl/button_event_gen.sv | 270 +++++++++++++++++++++++++++
 tb/tb_button_event_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//
// Turns debounced, sys_clock-synchronous button levels into discrete events
// for the game logic: PRESS (0), RELEASE (1), LONG (2) and REPEAT (3).
// One FSM per button feeds a one-entry pending slot. A fixed-priority arbiter
// (lowest index wins) moves at most one pending event per cycle into a
// show-ahead event FIFO. The consumer pops the FIFO with a valid/ready handshake.
//
// Optional feature macro: BUTTON_EVT_AUTO_REPEAT_EN
//   defined   : HELD emits REPEAT every REPEAT_MS while the button stays down
//   undefined : HELD is terminal until release and REPEAT is never emitted
//
// Ports
//   sys_clock     in   system clock
//   reset         in   asynchronous, active-high reset
//   button_level  in   [NUM_BUTTONS] debounced levels, 1 = pressed
//   evt_valid     out  FIFO head valid
//   evt_ready     in   consumer accepts the head event
//   evt_button    out  [BTN_W] button index of the head event
//   evt_type      out  [2] head event type
//   evt_overflow  out  sticky flag: an event was dropped
//   ovf_clr       in   single-cycle clear of evt_overflow
//   button_held   out  [NUM_BUTTONS] per-button FSM not IDLE
// -----------------------------------------------------------------------------
module button_event_gen #(
  parameter  int NUM_BUTTONS   = 4,
  parameter  int CLK_FREQ_HZ   = 100_000_000,
  parameter  int LONG_PRESS_MS = 500,
  parameter  int REPEAT_MS     = 100,
  parameter  int FIFO_DEPTH    = 4,
  localparam int BTN_W         = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic                   sys_clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] button_level,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [BTN_W-1:0]       evt_button,
  output logic [1:0]             evt_type,
  output logic                   evt_overflow,
  input  logic                   ovf_clr,
  output logic [NUM_BUTTONS-1:0] button_held
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX  = (LONG_PRESS_MS > REPEAT_MS) ? LONG_PRESS_MS : REPEAT_MS;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] EV_PRESS   = 2'd0;
  localparam logic [1:0] EV_RELEASE = 2'd1;
  localparam logic [1:0] EV_LONG    = 2'd2;
  localparam logic [1:0] EV_REPEAT  = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} state_t;

  // ---------------------------------------------------------------------------
  // Shared millisecond prescaler
  // ---------------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_reg;
  logic               ms_tick;

  assign ms_tick = (presc_reg == PRESC_W'(TICK_DIV - 1));

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset)        presc_reg <= '0;
    else if (ms_tick) presc_reg <= '0;
    else              presc_reg <= presc_reg + PRESC_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Level sampling and edge detect. The extra sampling stage gives the
  // press -> pending -> FIFO pipeline its fixed two-edge latency.
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] level_reg, prev_reg, rise, fall;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      level_reg <= '0;
      prev_reg  <= '0;
    end else begin
      level_reg <= button_level;
      prev_reg  <= level_reg;
    end
  end

  assign rise = level_reg & ~prev_reg;
  assign fall = ~level_reg & prev_reg;

  // ---------------------------------------------------------------------------
  // Per-button FSM + pending slot
  // ---------------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] pend_valid;
  logic [1:0]             pend_type [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] grant;
  logic [NUM_BUTTONS-1:0] drop;
  logic                   fifo_full;

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             held_reg;
    logic             pend_valid_reg;
    logic [1:0]       pend_type_reg;
    logic             press_hit, release_hit, long_hit, repeat_hit;
    logic             ev_valid;
    logic [1:0]       ev_type;

    // Event strobes; a fall masks a same-cycle LONG/REPEAT.
    assign press_hit   = (state_reg == ST_IDLE) && rise[gi];
    assign release_hit = (state_reg != ST_IDLE) && fall[gi];
    assign long_hit    = (state_reg == ST_PRESSED) && !fall[gi] && ms_tick &&
                         (cnt_reg == CNT_W'(LONG_PRESS_MS - 1));
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
    assign repeat_hit  = (state_reg == ST_HELD) && !fall[gi] && ms_tick &&
                         (cnt_reg == CNT_W'(REPEAT_MS - 1));
`else
    assign repeat_hit  = 1'b0;
`endif

    assign ev_valid = press_hit | release_hit | long_hit | repeat_hit;
    assign ev_type  = release_hit ? EV_RELEASE :
                      long_hit    ? EV_LONG    :
                      repeat_hit  ? EV_REPEAT  : EV_PRESS;

    // New event is lost only if the slot is full and not leaving this cycle.
    assign drop[gi] = ev_valid && pend_valid_reg && !grant[gi];

    always_ff @(posedge sys_clock or posedge reset) begin
      if (reset) begin
        state_reg      <= ST_IDLE;
        cnt_reg        <= '0;
        held_reg       <= 1'b0;
        pend_valid_reg <= 1'b0;
        pend_type_reg  <= EV_PRESS;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (press_hit) begin
              state_reg <= ST_PRESSED;
              cnt_reg   <= '0;
              held_reg  <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (release_hit) begin
              state_reg <= ST_IDLE;
              held_reg  <= 1'b0;
            end else if (long_hit) begin
              state_reg <= ST_HELD;
              cnt_reg   <= '0;
            end else if (ms_tick) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          ST_HELD: begin
            if (release_hit) begin
              state_reg <= ST_IDLE;
              held_reg  <= 1'b0;
            end
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
            else if (repeat_hit) begin
              cnt_reg <= '0;
            end else if (ms_tick) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
`endif
          end
          default: begin
            state_reg <= ST_IDLE;
            held_reg  <= 1'b0;
          end
        endcase

        if (ev_valid) begin
          if (!drop[gi]) begin
            pend_valid_reg <= 1'b1;
            pend_type_reg  <= ev_type;
          end
        end else if (grant[gi]) begin
          pend_valid_reg <= 1'b0;
        end
      end
    end

    assign pend_valid[gi]  = pend_valid_reg;
    assign pend_type[gi]   = pend_type_reg;
    assign button_held[gi] = held_reg;
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter: scan downwards so the lowest pending index wins.
  // ---------------------------------------------------------------------------
  logic             push;
  logic [BTN_W-1:0] push_button;
  logic [1:0]       push_type;

  always_comb begin
    push        = 1'b0;
    push_button = '0;
    push_type   = EV_PRESS;
    grant       = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        push        = 1'b1;
        push_button = BTN_W'(i);
        push_type   = pend_type[i];
      end
    end
    if (fifo_full) push = 1'b0;
    if (push) grant[push_button] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Show-ahead event FIFO. Full uses the registered count, so a pop does not
  // make room for a push in the same cycle.
  // ---------------------------------------------------------------------------
  logic [BTN_W-1:0] mem_button [FIFO_DEPTH];
  logic [1:0]       mem_type   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop;

  assign fifo_full = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign evt_valid = (count_reg != '0);
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_button[i] <= '0;
        mem_type[i]   <= EV_PRESS;
      end
    end else begin
      if (push) begin
        mem_button[wr_ptr_reg] <= push_button;
        mem_type[wr_ptr_reg]   <= push_type;
        wr_ptr_reg             <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign evt_button = mem_button[rd_ptr_reg];
  assign evt_type   = mem_type[rd_ptr_reg];

  // ---------------------------------------------------------------------------
  // Sticky overflow; a drop wins over a same-cycle clear.
  // ---------------------------------------------------------------------------
  logic ovf_reg;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset)        ovf_reg <= 1'b0;
    else if (|drop)   ovf_reg <= 1'b1;
    else if (ovf_clr) ovf_reg <= 1'b0;
  end

  assign evt_overflow = ovf_reg;

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// Self-checking bench for button_event_gen.
// An event-level reference model (tick counts since press, a queue for the
// FIFO, per-button pending slots) is compared to the DUT every cycle, and
// directed scenarios add hand-computed expectations on the popped event log.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

  localparam int NB      = 4;
  localparam int CLK_HZ  = 10_000;
  localparam int LONG_MS = 5;
  localparam int REP_MS  = 2;
  localparam int DEPTH   = 4;
  localparam int DIV     = CLK_HZ / 1000;

  logic          sys_clock = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] button_level = '0;
  logic          evt_ready = 1'b1;
  logic          ovf_clr = 1'b0;
  logic          evt_valid;
  logic [1:0]    evt_button;
  logic [1:0]    evt_type;
  logic          evt_overflow;
  logic [NB-1:0] button_held;

  button_event_gen #(
    .NUM_BUTTONS  (NB),
    .CLK_FREQ_HZ  (CLK_HZ),
    .LONG_PRESS_MS(LONG_MS),
    .REPEAT_MS    (REP_MS),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .sys_clock   (sys_clock),
    .reset       (reset),
    .button_level(button_level),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_button  (evt_button),
    .evt_type    (evt_type),
    .evt_overflow(evt_overflow),
    .ovf_clr     (ovf_clr),
    .button_held (button_held)
  );

  always #5 sys_clock = ~sys_clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct { int c; int b; int t; } rec_t;

  int            cyc;
  int            edge_cnt;
  logic [NB-1:0] m_lvl, m_prev;
  bit            m_held [NB];
  int            m_ticks [NB];
  bit            m_pv [NB];
  int            m_pt [NB];
  int            q_btn [$];
  int            q_typ [$];
  bit            m_ovf;
  rec_t          dut_log [$];

  always @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      edge_cnt = 0;
      m_lvl    = '0;
      m_prev   = '0;
      m_ovf    = 0;
      q_btn.delete();
      q_typ.delete();
      for (int i = 0; i < NB; i++) begin
        m_held[i] = 0; m_ticks[i] = 0; m_pv[i] = 0; m_pt[i] = 0;
      end
    end else begin
      int  g;
      int  evs [NB];
      bit  tick, full, pop, drop;
      cyc++;
      // Record what the DUT actually hands over at this edge.
      if (evt_valid && evt_ready) begin
        dut_log.push_back('{cyc, int'(evt_button), int'(evt_type)});
        $display("evt cyc=%0d button=%0d type=%0d", cyc, evt_button, evt_type);
      end
      edge_cnt++;
      tick = (edge_cnt % DIV) == 0;
      full = (q_btn.size() == DEPTH);
      pop  = (q_btn.size() > 0) && evt_ready;
      g = -1;
      if (!full)
        for (int i = 0; i < NB; i++)
          if (m_pv[i] && g < 0) g = i;
      for (int i = 0; i < NB; i++) begin
        bit r, f;
        r = m_lvl[i] && !m_prev[i];
        f = !m_lvl[i] && m_prev[i];
        evs[i] = -1;
        if (!m_held[i]) begin
          if (r) begin evs[i] = 0; m_held[i] = 1; m_ticks[i] = 0; end
        end else if (f) begin
          evs[i] = 1; m_held[i] = 0;
        end else if (tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == LONG_MS) evs[i] = 2;
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
          else if (m_ticks[i] > LONG_MS && ((m_ticks[i] - LONG_MS) % REP_MS) == 0) evs[i] = 3;
`endif
        end
      end
      if (pop) begin
        void'(q_btn.pop_front());
        void'(q_typ.pop_front());
      end
      if (g >= 0) begin
        q_btn.push_back(g);
        q_typ.push_back(m_pt[g]);
        m_pv[g] = 0;
      end
      drop = 0;
      for (int i = 0; i < NB; i++) begin
        if (evs[i] >= 0) begin
          if (m_pv[i]) drop = 1;
          else begin m_pv[i] = 1; m_pt[i] = evs[i]; end
        end
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
      m_prev = m_lvl;
      m_lvl  = button_level;
    end
  end

  // Per-cycle comparison against the model, 1 time unit after the edge.
  always @(posedge sys_clock) begin
    logic [NB-1:0] hv;
    #1;
    for (int i = 0; i < NB; i++) hv[i] = m_held[i];
    chk("cyc_valid", evt_valid, (q_btn.size() > 0) ? 1 : 0);
    if (q_btn.size() > 0) begin
      chk("cyc_head_button", evt_button, q_btn[0]);
      chk("cyc_head_type", evt_type, q_typ[0]);
    end
    chk("cyc_overflow", evt_overflow, m_ovf);
    chk("cyc_held", button_held, hv);
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  function automatic int lb(int i);
    if (i < dut_log.size()) return dut_log[i].b;
    return -1;
  endfunction
  function automatic int lt(int i);
    if (i < dut_log.size()) return dut_log[i].t;
    return -1;
  endfunction
  function automatic int lc(int i);
    if (i < dut_log.size()) return dut_log[i].c;
    return -1000;
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clock);
      #3;
    end
  endtask

`ifdef BUTTON_EVT_AUTO_REPEAT_EN
  int long_exp [5] = '{0, 2, 3, 3, 1};
`else
  int long_exp [3] = '{0, 2, 1};
`endif
  int bp_btn [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int bp_typ [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    int d;
    #1 reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    chk("reset_valid", evt_valid, 0);
    chk("reset_held", button_held, 0);
    chk("reset_overflow", evt_overflow, 0);

    // Short press on button 2.
    dut_log.delete();
    button_level[2] = 1'b1;
    cycles(1);
    chk("short_valid_k", evt_valid, 0);
    cycles(1);
    chk("short_valid_k1", evt_valid, 0);
    cycles(1);
    chk("short_valid_k2", evt_valid, 1);
    cycles(17);
    button_level[2] = 1'b0;
    cycles(10);
    chk("short_count", dut_log.size(), 2);
    chk("short_e0_button", lb(0), 2);
    chk("short_e0_type", lt(0), 0);
    chk("short_e1_button", lb(1), 2);
    chk("short_e1_type", lt(1), 1);

    // Long press with (optional) repeats on button 0.
    dut_log.delete();
    button_level[0] = 1'b1;
    cycles(100);
    button_level[0] = 1'b0;
    cycles(10);
    chk("long_count", dut_log.size(), $size(long_exp));
    for (int i = 0; i < $size(long_exp); i++) begin
      chk("long_button", lb(i), 0);
      chk("long_type", lt(i), long_exp[i]);
    end
    d = lc(1) - lc(0);
    chk("long_delay_40_50", (d >= 40 && d <= 50) ? 1 : 0, 1);
`ifdef BUTTON_EVT_AUTO_REPEAT_EN
    chk("repeat_gap1", lc(2) - lc(1), 20);
    chk("repeat_gap2", lc(3) - lc(2), 20);
`endif

    // Simultaneous press of buttons 3 and 1.
    dut_log.delete();
    button_level = 4'b1010;
    cycles(6);
    chk("simul_count", dut_log.size(), 2);
    chk("simul_first", lb(0), 1);
    chk("simul_second", lb(1), 3);
    chk("simul_spacing", lc(1) - lc(0), 1);
    button_level = 4'b0000;
    cycles(8);

    // Backpressure and overflow.
    evt_ready = 1'b0;
    dut_log.delete();
    button_level = 4'b1111;
    cycles(8);
    button_level = 4'b0000;
    cycles(8);
    chk("bp_valid", evt_valid, 1);
    chk("bp_head_button", evt_button, 0);
    chk("bp_head_type", evt_type, 0);
    chk("bp_overflow_before", evt_overflow, 0);
    button_level[0] = 1'b1;
    cycles(4);
    chk("bp_overflow_set", evt_overflow, 1);
    evt_ready = 1'b1;
    cycles(14);
    chk("bp_drain_count", dut_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("bp_drain_button", lb(i), bp_btn[i]);
      chk("bp_drain_type", lt(i), bp_typ[i]);
    end
    chk("bp_overflow_sticky", evt_overflow, 1);
    ovf_clr = 1'b1;
    cycles(1);
    ovf_clr = 1'b0;
    chk("bp_overflow_clr", evt_overflow, 0);
    button_level[0] = 1'b0;
    cycles(6);

    // Reset while button 1 is HELD with two events queued.
    evt_ready = 1'b0;
    dut_log.delete();
    button_level[1] = 1'b1;
    cycles(56);
    chk("mid_held", button_held[1], 1);
    chk("mid_valid", evt_valid, 1);
    chk("mid_head_button", evt_button, 1);
    chk("mid_head_type", evt_type, 0);
    reset = 1'b1;
    #1;
    chk("mid_reset_valid", evt_valid, 0);
    chk("mid_reset_held", button_held, 0);
    cycles(2);
    reset = 1'b0;
    evt_ready = 1'b1;
    cycles(6);
    chk("after_reset_count", dut_log.size(), 1);
    chk("after_reset_button", lb(0), 1);
    chk("after_reset_type", lt(0), 0);
    button_level[1] = 1'b0;
    cycles(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
